pwm_cfg_sequencer: RTL and testbench
====================================

PWM_CFG_SEQUENCER -- requirements
Module: pwm_cfg_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 16: register data width.
REQ-002 SHALL have port clk_psc_i  in  1  clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n_i  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start_i  in  1  request to load a new configuration.
REQ-005 SHALL have ports psc_i, arr_i, cmp_start_i, cmp_end_i, cfg_i  in  WIDTH  each; dtg_i  in  8; en_after_i  in  1  (new configuration and post-load enable).
REQ-006 SHALL have ports host_req_i  in  1, host_wr_i  in  1, host_addr_i  in  8, host_wdata_i  in  WIDTH  (host register access).
REQ-007 SHALL have port host_gnt_o  out  1  (host owns the register bus this cycle).
REQ-008 SHALL have ports wr_en_o  out  1, rd_en_o  out  1, addr_o  out  8, wr_data_o  out  WIDTH  (register bus to the PWM register block).
REQ-009 SHALL have ports busy_o  out  1; done_o  out  1; err_o  out  1  (status).

Function
REQ-010 SHALL implement FSM states IDLE, CHECK, DIS, W_PSC, W_ARR, W_CS, W_CE, W_DTG, W_CFG, EN, DONE, ERR.
REQ-011 In IDLE, when start_i=1, SHALL capture all config inputs and en_after_i into internal latches and go to CHECK; later input changes are ignored until the next start.
REQ-012 CHECK SHALL go to ERR if arr==0, cmp_start>cmp_end or cmp_end>arr (unsigned, latched values); otherwise it SHALL go to DIS.
REQ-013 DIS, W_PSC, W_ARR, W_CS, W_CE, W_DTG, W_CFG SHALL last one cycle each, writing addr 0/1/2/3/4/5/6 with data 0/psc/arr/cmp_start/cmp_end/{0,dtg}/cfg respectively.
REQ-014 After W_CFG, SHALL go to EN if en_after=1, else to DONE; EN SHALL write addr 0 with data 1 for one cycle, then go to DONE.
REQ-015 DONE and ERR SHALL last one cycle, assert done_o or err_o respectively for that cycle only, and return to IDLE.
REQ-016 Sequencer bus outputs SHALL be Moore-decoded from the state: wr_en_o=1 only in write states; rd_en_o=0 throughout a sequence.
REQ-017 Outputs SHALL be wr_en_o=0, addr_o=0, wr_data_o=0 in CHECK, DONE, ERR and in IDLE without a grant.
REQ-018 host_gnt_o SHALL equal host_req_i AND state==IDLE AND NOT start_i (combinational); start_i wins a same-cycle tie.
REQ-019 While host_gnt_o=1: addr_o=host_addr_i, wr_data_o=host_wdata_i, wr_en_o=host_wr_i, rd_en_o=NOT host_wr_i.
REQ-020 busy_o SHALL be 1 in every state except IDLE.
REQ-021 start_i while busy_o=1 SHALL be ignored, not queued; host_req_i while busy_o=1 SHALL wait with host_gnt_o=0.
REQ-022 Latency SHALL be: start at edge T0, CHECK in cycle 1, DIS in cycle 2, W_CFG in cycle 8, EN in cycle 9 if enabled, DONE in cycle 9 or 10; ERR in cycle 2.
REQ-023 The DIS write SHALL always precede any other write within a sequence, so the counter is stopped while its registers change.

Reset
REQ-024 rst_n_i=0 SHALL immediately force IDLE, clear all latches, and drive all outputs to 0, including mid-sequence; no further writes of the aborted sequence SHALL occur.
REQ-025 After reset release, the first accepted start SHALL run a complete sequence from CHECK.

Verification
REQ-026 start with psc=3, arr=99, cs=10, ce=50, dtg=4, cfg=1, en_after=1 -> writes (0,0),(1,3),(2,99),(3,10),(4,50),(5,4),(6,1),(0,1) in cycles 2-9; done_o in cycle 10.
REQ-027 Same config with en_after=0 -> no second addr-0 write; done_o in cycle 9.
REQ-028 cs=60, ce=50, arr=99 -> err_o in cycle 2, no wr_en_o pulse, done_o stays 0; arr=0 gives the same result.
REQ-029 host_req_i=1 and start_i=1 in the same IDLE cycle -> host_gnt_o=0 and the sequence runs; host is granted in the first IDLE cycle after DONE, and the bus mirrors the host inputs.
REQ-030 rst_n_i pulsed low during W_ARR -> outputs 0 at once; no W_CS write follows; busy_o=0.
REQ-031 Second start pulse during W_DTG -> ignored; exactly one done_o pulse.

Source files
------------

// File: rtl/pwm_cfg_sequencer.sv
// Sequences a new configuration into the PWM register block: disable, write
// all timing registers, optionally re-enable. Arbitrates idle bus with a host.
module pwm_cfg_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk_psc_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] psc_i,
  input  logic [WIDTH-1:0] arr_i,
  input  logic [WIDTH-1:0] cmp_start_i,
  input  logic [WIDTH-1:0] cmp_end_i,
  input  logic [WIDTH-1:0] cfg_i,
  input  logic [7:0]       dtg_i,
  input  logic             en_after_i,
  input  logic             host_req_i,
  input  logic             host_wr_i,
  input  logic [7:0]       host_addr_i,
  input  logic [WIDTH-1:0] host_wdata_i,
  output logic             host_gnt_o,
  output logic             wr_en_o,
  output logic             rd_en_o,
  output logic [7:0]       addr_o,
  output logic [WIDTH-1:0] wr_data_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_CHECK = 4'd1,
    S_DIS   = 4'd2,
    S_W_PSC = 4'd3,
    S_W_ARR = 4'd4,
    S_W_CS  = 4'd5,
    S_W_CE  = 4'd6,
    S_W_DTG = 4'd7,
    S_W_CFG = 4'd8,
    S_EN    = 4'd9,
    S_DONE  = 4'd10,
    S_ERR   = 4'd11
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] psc_r;
  logic [WIDTH-1:0] arr_r;
  logic [WIDTH-1:0] cs_r;
  logic [WIDTH-1:0] ce_r;
  logic [WIDTH-1:0] cfg_r;
  logic [7:0]       dtg_r;
  logic             en_after_r;

  logic             cfg_bad_s;
  logic             host_gnt_s;
  logic             seq_we_s;
  logic [7:0]       seq_addr_s;
  logic [WIDTH-1:0] seq_data_s;

  assign cfg_bad_s = (arr_r == {WIDTH{1'b0}}) || (cs_r > ce_r) || (ce_r > arr_r);

  // Start wins a same-cycle tie; reset also masks the grant so every output is 0.
  assign host_gnt_s = rst_n_i & host_req_i & (state_r == S_IDLE) & ~start_i;

  // Sequencer state and configuration capture.
  always_ff @(posedge clk_psc_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r    <= S_IDLE;
      psc_r      <= {WIDTH{1'b0}};
      arr_r      <= {WIDTH{1'b0}};
      cs_r       <= {WIDTH{1'b0}};
      ce_r       <= {WIDTH{1'b0}};
      cfg_r      <= {WIDTH{1'b0}};
      dtg_r      <= 8'd0;
      en_after_r <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start_i) begin
            psc_r      <= psc_i;
            arr_r      <= arr_i;
            cs_r       <= cmp_start_i;
            ce_r       <= cmp_end_i;
            cfg_r      <= cfg_i;
            dtg_r      <= dtg_i;
            en_after_r <= en_after_i;
            state_r    <= S_CHECK;
          end else begin
            state_r    <= S_IDLE;
          end
        end
        S_CHECK: state_r <= cfg_bad_s ? S_ERR : S_DIS;
        S_DIS:   state_r <= S_W_PSC;
        S_W_PSC: state_r <= S_W_ARR;
        S_W_ARR: state_r <= S_W_CS;
        S_W_CS:  state_r <= S_W_CE;
        S_W_CE:  state_r <= S_W_DTG;
        S_W_DTG: state_r <= S_W_CFG;
        S_W_CFG: state_r <= en_after_r ? S_EN : S_DONE;
        S_EN:    state_r <= S_DONE;
        S_DONE:  state_r <= S_IDLE;
        S_ERR:   state_r <= S_IDLE;
        default: state_r <= S_IDLE;
      endcase
    end
  end

  // Moore decode of the sequencer write for each state.
  always_comb begin
    seq_we_s   = 1'b1;
    seq_addr_s = 8'd0;
    seq_data_s = {WIDTH{1'b0}};
    case (state_r)
      S_DIS:   begin seq_addr_s = 8'd0; seq_data_s = {WIDTH{1'b0}}; end
      S_W_PSC: begin seq_addr_s = 8'd1; seq_data_s = psc_r; end
      S_W_ARR: begin seq_addr_s = 8'd2; seq_data_s = arr_r; end
      S_W_CS:  begin seq_addr_s = 8'd3; seq_data_s = cs_r; end
      S_W_CE:  begin seq_addr_s = 8'd4; seq_data_s = ce_r; end
      S_W_DTG: begin seq_addr_s = 8'd5; seq_data_s = {{(WIDTH-8){1'b0}}, dtg_r}; end
      S_W_CFG: begin seq_addr_s = 8'd6; seq_data_s = cfg_r; end
      S_EN:    begin seq_addr_s = 8'd0; seq_data_s = {{(WIDTH-1){1'b0}}, 1'b1}; end
      default: begin seq_we_s = 1'b0; seq_addr_s = 8'd0; seq_data_s = {WIDTH{1'b0}}; end
    endcase
  end

  // Bus mux: a granted host drives the bus directly, otherwise the sequencer does.
  always_comb begin
    if (host_gnt_s) begin
      wr_en_o   = host_wr_i;
      rd_en_o   = ~host_wr_i;
      addr_o    = host_addr_i;
      wr_data_o = host_wdata_i;
    end else begin
      wr_en_o   = seq_we_s;
      rd_en_o   = 1'b0;
      addr_o    = seq_addr_s;
      wr_data_o = seq_data_s;
    end
  end

  assign host_gnt_o = host_gnt_s;
  assign busy_o     = (state_r != S_IDLE);
  assign done_o     = (state_r == S_DONE);
  assign err_o      = (state_r == S_ERR);

endmodule

// File: tb/tb_pwm_cfg_sequencer.sv
// Directed and randomized checks of pwm_cfg_sequencer against a cycle-indexed
// model of the expected write list.
module tb_pwm_cfg_sequencer;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] psc, arr, cs, ce, cfg;
  logic [7:0]   dtg;
  logic         en_after;
  logic         host_req, host_wr;
  logic [7:0]   host_addr;
  logic [W-1:0] host_wdata;
  logic         host_gnt, wr_en, rd_en, busy, done, err;
  logic [7:0]   addr;
  logic [W-1:0] wr_data;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pwm_cfg_sequencer #(.WIDTH(W)) dut (
    .clk_psc_i(clk), .rst_n_i(rst_n), .start_i(start),
    .psc_i(psc), .arr_i(arr), .cmp_start_i(cs), .cmp_end_i(ce), .cfg_i(cfg),
    .dtg_i(dtg), .en_after_i(en_after),
    .host_req_i(host_req), .host_wr_i(host_wr), .host_addr_i(host_addr),
    .host_wdata_i(host_wdata), .host_gnt_o(host_gnt),
    .wr_en_o(wr_en), .rd_en_o(rd_en), .addr_o(addr), .wr_data_o(wr_data),
    .busy_o(busy), .done_o(done), .err_o(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic scramble_cfg();
    psc = W'($urandom); arr = W'($urandom); cs = W'($urandom); ce = W'($urandom);
    cfg = W'($urandom); dtg = 8'($urandom); en_after = 1'($urandom);
  endtask

  // Runs one start request from IDLE (called just after a rising edge) and
  // checks every output in every cycle up to cycle 12 against the write list.
  task automatic run_seq(input logic [W-1:0] p, a, s, e, c, input logic [7:0] d,
                         input logic en, input int restart_at, input bit tie);
    int  qa[$];
    int  qd[$];
    bit  valid;
    int  last;
    int  dones;
    bit  exp_we;
    int  ea, ed;
    valid = (a != 0) && (s <= e) && (e <= a);
    if (valid) begin
      qa.push_back(0); qd.push_back(0);
      qa.push_back(1); qd.push_back(int'(p));
      qa.push_back(2); qd.push_back(int'(a));
      qa.push_back(3); qd.push_back(int'(s));
      qa.push_back(4); qd.push_back(int'(e));
      qa.push_back(5); qd.push_back(int'(d));
      qa.push_back(6); qd.push_back(int'(c));
      if (en) begin qa.push_back(0); qd.push_back(1); end
    end
    last = valid ? 2 + qa.size() : 2;
    psc = p; arr = a; cs = s; ce = e; cfg = c; dtg = d; en_after = en;
    start = 1'b1; host_req = tie; host_wr = 1'b1;
    @(negedge clk);
    if (tie) chk("tie_gnt", host_gnt, 0);
    @(posedge clk); #1;
    dones = 0;
    for (int cy = 1; cy <= 12; cy++) begin
      scramble_cfg();
      start      = (cy == restart_at);
      host_req   = (tie && cy == last + 1) ? 1'b1 : 1'($urandom);
      host_wr    = 1'($urandom);
      host_addr  = 8'($urandom);
      host_wdata = W'($urandom);
      @(negedge clk);
      if (cy <= last) begin
        exp_we = valid && cy >= 2 && cy < 2 + qa.size();
        ea = exp_we ? qa[cy-2] : 0;
        ed = exp_we ? qd[cy-2] : 0;
        chk("busy", busy, 1);
        chk("gnt_busy", host_gnt, 0);
        chk("wr_en", wr_en, exp_we);
        chk("rd_en", rd_en, 0);
        chk("addr", addr, ea);
        chk("wr_data", wr_data, ed);
        chk("done", done, valid && cy == last);
        chk("err", err, !valid && cy == last);
      end else begin
        chk("busy_idle", busy, 0);
        chk("gnt_idle", host_gnt, host_req);
        chk("host_wr_en", wr_en, host_req ? host_wr : 1'b0);
        chk("host_rd_en", rd_en, host_req ? !host_wr : 1'b0);
        chk("host_addr", addr, host_req ? host_addr : 8'd0);
        chk("host_data", wr_data, host_req ? host_wdata : 16'd0);
        chk("done_idle", done, 0);
        chk("err_idle", err, 0);
      end
      dones += int'(done);
      @(posedge clk); #1;
    end
    chk("done_count", dones, valid ? 1 : 0);
    start = 1'b0; host_req = 1'b0;
  endtask

  initial begin
    logic [W-1:0] ra, rc;
    rst_n = 1'b0; start = 1'b0; host_req = 1'b1; host_wr = 1'b1;
    host_addr = 8'h5a; host_wdata = 16'h1234;
    psc = '0; arr = '0; cs = '0; ce = '0; cfg = '0; dtg = '0; en_after = 1'b0;
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_gnt", host_gnt, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_addr", addr, 0);
    chk("rst_data", wr_data, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    @(posedge clk); #1;
    rst_n = 1'b1; host_req = 1'b0;
    @(posedge clk); #1;

    // Directed scenarios: enable, no enable, two error cases, tie, ignored restart.
    run_seq(16'd3, 16'd99, 16'd10, 16'd50, 16'd1, 8'd4, 1'b1, 0, 1'b0);
    run_seq(16'd3, 16'd99, 16'd10, 16'd50, 16'd1, 8'd4, 1'b0, 0, 1'b0);
    run_seq(16'd3, 16'd99, 16'd60, 16'd50, 16'd1, 8'd4, 1'b1, 0, 1'b0);
    run_seq(16'd3, 16'd0,  16'd0,  16'd0,  16'd1, 8'd4, 1'b1, 0, 1'b0);
    run_seq(16'd3, 16'd99, 16'd10, 16'd50, 16'd1, 8'd4, 1'b1, 0, 1'b1);
    run_seq(16'd3, 16'd99, 16'd10, 16'd50, 16'd1, 8'd4, 1'b1, 7, 1'b0);
    run_seq(16'd7, 16'd50, 16'd50, 16'd50, 16'd2, 8'd9, 1'b0, 0, 1'b0);

    // Reset pulse in the W_ARR cycle aborts the sequence.
    psc = 16'd3; arr = 16'd99; cs = 16'd10; ce = 16'd50; cfg = 16'd1; dtg = 8'd4;
    en_after = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("pre_rst_wr_en", wr_en, 1);
    chk("pre_rst_addr", addr, 2);
    chk("pre_rst_data", wr_data, 99);
    #2;
    rst_n = 1'b0; host_req = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_wr_en", wr_en, 0);
    chk("abort_addr", addr, 0);
    chk("abort_data", wr_data, 0);
    chk("abort_gnt", host_gnt, 0);
    @(posedge clk); #1;
    rst_n = 1'b1; host_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("post_rst_wr_en", wr_en, 0);
      chk("post_rst_busy", busy, 0);
    end
    @(posedge clk); #1;

    run_seq(16'd3, 16'd99, 16'd10, 16'd50, 16'd1, 8'd4, 1'b1, 0, 1'b0);

    // Randomized configurations, half of them valid by construction.
    for (int k = 0; k < 24; k++) begin
      if ($urandom_range(0, 1) == 0) begin
        ra = W'($urandom_range(1, 60000));
        rc = W'($urandom_range(0, int'(ra)));
        run_seq(W'($urandom), ra, W'($urandom_range(0, int'(rc))), rc, W'($urandom),
                8'($urandom), 1'($urandom), $urandom_range(0, 1) == 0 ? 0 : 5, 1'($urandom));
      end else begin
        run_seq(W'($urandom), W'($urandom_range(0, 3)), W'($urandom_range(0, 4)),
                W'($urandom_range(0, 4)), W'($urandom), 8'($urandom), 1'($urandom),
                0, 1'($urandom));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
